// File: rtl/lfsr_pkg.sv
// Shared constants for the 4-bit Fibonacci LFSR (polynomial x^4 + x^3 + 1).
//   LFSR_WIDTH     : register width
//   LFSR_RESET_VAL : value forced by the synchronous reset
//   TAP_HI/TAP_LO  : state bits XORed to form the feedback bit
package lfsr_pkg;
  localparam int unsigned LFSR_WIDTH = 4;
  localparam logic [LFSR_WIDTH-1:0] LFSR_RESET_VAL = 4'b0000;
  localparam int unsigned TAP_HI = 3;
  localparam int unsigned TAP_LO = 2;
endpackage : lfsr_pkg

// File: rtl/lfsr_bit_cell.sv
// One LFSR bit: a 2:1 mux (load or shift) feeding a D flip-flop with a
// synchronous active-high reset.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, forces q to RESET_BIT
//   sel     : 1 = capture load_d, 0 = capture shift_d
//   load_d  : seed bit
//   shift_d : shift-in bit from the neighbouring cell or the feedback gate
//   q       : registered bit
module lfsr_bit_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic load_d,
  input  logic shift_d,
  output logic q
);

  logic bit_d;
  logic bit_q;

  always_comb begin
    bit_d = shift_d;
    if (sel) begin
      bit_d = load_d;
    end
  end

  // reset takes priority over the load/shift mux
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q <= RESET_BIT;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule : lfsr_bit_cell

// File: rtl/lfsr_struct.sv
// 4-bit Fibonacci LFSR built from four lfsr_bit_cell instances and one XOR
// feedback gate. Left shift with the feedback bit entering bit 0; the
// sequence from any non-zero seed has period 15. All-zero is a lockup state
// that only a non-zero seed load leaves.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (state -> 0000), beats sel
//   seed  : value loaded when sel=1
//   sel   : 1 = load seed, 0 = LFSR step
//   state : register contents, straight from the flip-flops
module lfsr_struct
  import lfsr_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  sel,
  output logic [LFSR_WIDTH-1:0] state
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] shift_d;
  logic                  feedback;

  assign feedback = state_q[TAP_HI] ^ state_q[TAP_LO];

  // cell 0 takes the feedback bit, cell i takes state[i-1]
  assign shift_d = {state_q[LFSR_WIDTH-2:0], feedback};

  for (genvar i = 0; i < LFSR_WIDTH; i++) begin : g_cell
    lfsr_bit_cell #(
      .RESET_BIT (LFSR_RESET_VAL[i])
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .sel     (sel),
      .load_d  (seed[i]),
      .shift_d (shift_d[i]),
      .q       (state_q[i])
    );
  end

  assign state = state_q;

endmodule : lfsr_struct

// File: tb/tb_lfsr_struct.sv
module tb_lfsr_struct;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       sel;
  logic [3:0] seed;
  logic [3:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lfsr_struct dut (
    .clk   (clk),
    .reset (reset),
    .seed  (seed),
    .sel   (sel),
    .state (state)
  );

  // ---------------- reference sequence ----------------
  logic [3:0] seq_tbl [0:14] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  function automatic logic [3:0] succ(input logic [3:0] s);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < 15; k++) begin
      if (seq_tbl[k] == s) r = seq_tbl[(k + 1) % 15];
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         n_assert;
  int         n_fail;
  logic [15:0] seen;
  logic [3:0]  model;

  task automatic check_out(input string tag);
    logic [3:0] exp;
    exp = exp_q.pop_front();
    n_assert++;
    assert (state === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, state, exp);
    end
    if (!$isunknown(state)) seen[state] = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_edge(input logic r, input logic s, input logic [3:0] sd,
                            input logic [3:0] exp, input string tag);
    @(negedge clk);
    reset = r;
    sel   = s;
    seed  = sd;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input string tag);
    drive_edge(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'h0, tag);
    model = 4'h0;
  endtask

  task automatic do_load(input logic [3:0] sd, input string tag);
    drive_edge(1'b0, 1'b1, sd, sd, tag);
    model = sd;
  endtask

  // seed is randomised while shifting: it must have no effect
  task automatic do_steps(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      model = succ(model);
      drive_edge(1'b0, 1'b0, 4'($urandom_range(0, 15)), model, tag);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    seen     = '0;
    model    = 4'h0;
    reset    = 1'b0;
    sel      = 1'b0;
    seed     = 4'h0;

    do_reset("reset_from_x");
    do_load(4'hA, "pre_reset_load");
    do_steps(2, "pre_reset_step");
    do_reset("reset_mid_state");
    drive_edge(1'b1, 1'b1, 4'hF, 4'h0, "reset_beats_sel");
    model = 4'h0;
    do_steps(1, "post_reset_lockup");

    // full period from 1111: 15th step returns to 1111, 16th gives 1110
    do_load(4'hF, "load_f");
    for (int k = 1; k <= 16; k++) begin
      drive_edge(1'b0, 1'b0, 4'($urandom_range(0, 15)), seq_tbl[k % 15], "full_period");
    end
    model = 4'hE;

    do_load(4'hA, "load_a");
    do_steps(7, "seq_from_a");

    do_load(4'h9, "load_9");
    do_steps(5, "seq_from_9");

    do_load(4'h0, "load_zero");
    do_steps(5, "lockup");
    do_load(4'h1, "escape_load_1");
    do_steps(3, "seq_from_1");

    for (int k = 0; k < 3; k++) begin
      do_load(4'h6, "held_load");
    end
    do_steps(4, "steps_before_reset");
    do_reset("reset_mid_run");
    do_steps(2, "lockup_after_reset");

    n_assert++;
    assert (seen === 16'hFFFF) else begin
      n_fail++;
      $error("FAIL state_coverage: observed %h expected %h", seen, 16'hFFFF);
    end
    n_assert++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_lfsr_struct
